dmem_line_responder: RTL
========================

// Module: dmem_line_responder
// PURPOSE
//  Responder end of the 256-bit line interface driven by the data-cache controller.
//  Accepts one line read or line write per request and performs it after a fixed latency.
//  Signals completion with a one-cycle ack, and returns read data in that same cycle.
//  Sits between the dcache mem_* ports and the backing line store; it is also the bench memory model.
// PARAMETERS
//  LATENCY     10    cycles from request acceptance to ack_o; legal range >= 1
//  DEPTH       512   number of 256-bit lines in the store; power of 2
//  LINE_W      256   line width in bits; fixed by the cache interface
// PORTS
//  clk_i     in   1    system clock; everything is on posedge
//  rst_i     in   1    asynchronous, active-low reset
//  enable_i  in   1    request valid; held high by the initiator until it samples ack_o
//  write_i   in   1    1 = line write, 0 = line read; sampled only at acceptance
//  addr_i    in   32   byte address; bits [4:0] ignored; line index = addr_i[5 +: log2(DEPTH)]
//  data_i    in   256  write line; sampled only at acceptance
//  ack_o     out  1    completion pulse; high for exactly one cycle per accepted request
//  data_o    out  256  read line; valid while ack_o is high, held until the next read completes
// BEHAVIOUR
//  Reset (async, rst_i low):
//   - state = IDLE, ack_o = 0, data_o = 0, counter = 0.
//   - Store contents are not reset.
//   - A transaction in flight is aborted; no write is committed.
//  States:
//   - IDLE: if enable_i = 1 at a posedge, accept. Latch write_i, addr index and data_i, load counter = LATENCY-1, go to WAIT.
//   - WAIT: counter decrements once per cycle. When counter = 0, do the access at that edge:
//     write -> store[idx] <= latched data; read -> data_o <= store[idx].
//     Same edge: ack_o <= 1, go to ACK.
//   - ACK: ack_o = 1 for this one cycle. At the next edge ack_o <= 0. Then:
//     if enable_i = 1 at that edge, accept a new request immediately (back-to-back, e.g. writeback then refill);
//     otherwise go to IDLE.
//  Latency:
//   - Accept at edge E0 -> ack_o high during cycle [E0+LATENCY, E0+LATENCY+1).
//   - LATENCY = 1 means ack in the cycle right after acceptance.
//  Initiator contract:
//   - The initiator deasserts enable_i at the edge where it samples ack_o.
//   - If enable_i is still high at the edge that ends ACK, that is a new request, using the addr/write/data present then.
//  Boundary cases:
//   - enable_i dropping during WAIT is ignored; the transaction still completes and acks.
//   - addr_i / data_i changing during WAIT is ignored; the latched copies are used.
//   - Address bits above the index are ignored, so addresses wrap modulo DEPTH lines.
//   - Read after write to the same line, back-to-back, returns the new data: the write committed at the earlier ACK edge.
//   - Only one transaction is ever outstanding; ack_o is never high in two consecutive cycles
//     unless there are two accepted requests.
//  Width and arithmetic:
//   - counter width is $clog2(LATENCY+1). It is unsigned and never underflows: it is only decremented in WAIT while nonzero.
//   - data_o only changes on a read completion, or on reset.
// STRUCTURE
//  Package dmem_pkg:
//   - constants LINE_W=256, ADDR_W=32, OFFSET_W=5
//   - typedef for the IDLE/WAIT/ACK state enum
//   - typedef line_t = logic[LINE_W-1:0]
//  Sub-module dmem_line_array: single-port synchronous line store.
//   - ports: clk_i, we_i, idx_i, wdata_i, rdata_o
//   - registered read; supports $readmemh preload for benches.
//  Top level holds the FSM, the latency counter and the request latches.
// TESTING
//  1. Reset, then read of line 3 (addr 0x60; store preloaded 256'hA5..A5) with LATENCY = 10
//     -> ack_o high exactly in cycle 10 after acceptance; data_o = 256'hA5..A5.
//  2. Write 256'h1234..F0 to addr 0x0000_0400, then read addr 0x0000_0410 (same line, offset ignored)
//     -> the read returns 256'h1234..F0.
//  3. Back-to-back with enable_i held high through ack: writeback of line 7, then refill of line 39 (DEPTH = 32)
//     -> two ack pulses exactly LATENCY+1 cycles apart; line 7 updated;
//        the refill returns line 39 mod 32 = line 7's new data.
//  4. Drop enable_i and scramble addr_i/data_i during WAIT of a write to line 5
//     -> ack still fires at cycle LATENCY; line 5 holds the originally latched data.
//  5. Assert rst_i low in cycle 4 of a write with LATENCY = 10
//     -> ack_o = 0 and data_o = 0 immediately; the line is unchanged; a fresh read works normally.
//  6. LATENCY = 1 read -> ack_o in the cycle right after acceptance; ack_o is never high for two cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the 256-bit line responder
package dmem_pkg;
    localparam int LINE_W   = 256;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;
    typedef logic [LINE_W-1:0] line_t;
endpackage

// File: rtl/dmem_line_array.sv
// dmem_line_array: single-port synchronous line store with registered read
// ports: clk_i clock, we_i write enable, idx_i line index, wdata_i write line, rdata_o line read at idx_i (one-cycle latency)
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  line_t                    wdata_i,
    output line_t                    rdata_o
);
    line_t mem [DEPTH];
    always_ff @(posedge clk_i) begin
        if (we_i) mem[idx_i] <= wdata_i;
        rdata_o <= mem[idx_i];
    end
endmodule

// File: rtl/dmem_line_responder.sv
// dmem_line_responder: fixed-latency line read/write responder for the dcache line interface
// ports: clk_i clock, rst_i async active-low reset, enable_i request valid, write_i 1=write,
//        addr_i byte address, data_i write line, ack_o one-cycle completion, data_o last read line
module dmem_line_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  line_t             data_i,
    output logic              ack_o,
    output line_t             data_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             wr_q, accept, done, we;
    logic [IDX_W-1:0] idx_q, idx;
    line_t            data_q, rdata;
    logic             unused_addr;
    assign unused_addr = ^{addr_i[OFFSET_W-1:0], addr_i[ADDR_W-1:OFFSET_W+IDX_W]};
    // The store is addressed by the incoming index at acceptance so its registered
    // read is already valid by the completion edge, even with LATENCY = 1.
    always_comb begin
        accept    = enable_i && (state != ST_WAIT);
        done      = (state == ST_WAIT) && (cnt == '0);
        we        = done && wr_q;
        idx       = (state == ST_WAIT) ? idx_q : addr_i[OFFSET_W +: IDX_W];
        state_nxt = (state == ST_WAIT) ? (done ? ST_ACK : ST_WAIT) : (enable_i ? ST_WAIT : ST_IDLE);
        ack_o     = (state == ST_ACK);
    end
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) state <= ST_IDLE;
        else        state <= state_nxt;
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            cnt    <= '0;
            wr_q   <= 1'b0;
            idx_q  <= '0;
            data_q <= '0;
            data_o <= '0;
        end else begin
            if (accept) begin
                cnt    <= CNT_W'(LATENCY - 1);
                wr_q   <= write_i;
                idx_q  <= idx;
                data_q <= data_i;
            end else if (state == ST_WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (done && !wr_q) data_o <= rdata;
        end
    dmem_line_array #(.DEPTH(DEPTH)) u_array (
        .clk_i  (clk_i),
        .we_i   (we),
        .idx_i  (idx),
        .wdata_i(data_q),
        .rdata_o(rdata)
    );
endmodule
